// File: rtl/rx_frame_ctrl.sv
// rx_frame_ctrl: optical-line frame receiver (start=1, LSB-first payload, stop=0) with valid/ready output hold.
module rx_frame_ctrl #(
    parameter int BIT_PERIOD = 54,
    parameter int DATA_BITS  = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 rx_in,
    input  logic                 data_ready,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);
    localparam int H  = BIT_PERIOD / 2;
    localparam int CW = $clog2(BIT_PERIOD);
    localparam int BW = $clog2(DATA_BITS + 1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, RECOVER} state_t;

    state_t               state_q, state_d;
    logic [1:0]           sync_q;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [BW-1:0]        bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d, dout_q, dout_d;
    logic                 valid_q, valid_d, ferr_q, ferr_d, ovr_q, ovr_d;
    logic                 rx_s, tick, complete, load;

    assign rx_s = sync_q[1];
    assign tick = cnt_q == CW'(BIT_PERIOD - 1);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q + CW'(1);
        bit_d    = bit_q;
        shift_d  = shift_q;
        complete = 1'b0;
        ferr_d   = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                bit_d = '0;
                if (rx_s) begin
                    state_d = START;
                    shift_d = '0;
                end
            end
            START: if (cnt_q == CW'(H - 1)) begin
                cnt_d   = '0;
                state_d = rx_s ? DATA : IDLE;
            end
            DATA: if (tick) begin
                cnt_d   = '0;
                shift_d = (shift_q >> 1) | (DATA_BITS'(rx_s) << (DATA_BITS - 1));
                bit_d   = bit_q + BW'(1);
                if (bit_q == BW'(DATA_BITS - 1)) state_d = STOP;
            end
            STOP: if (tick) begin
                cnt_d    = '0;
                ferr_d   = rx_s;
                complete = !rx_s;
                state_d  = rx_s ? RECOVER : IDLE;
            end
            RECOVER: begin
                cnt_d = '0;
                if (!rx_s) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // Dropping enable wins over any sample taken in the same cycle.
        if (!enable) begin
            state_d  = IDLE;
            cnt_d    = '0;
            complete = 1'b0;
            ferr_d   = 1'b0;
        end
        load    = complete && (!valid_q || data_ready);
        dout_d  = load ? shift_q : dout_q;
        valid_d = load || (valid_q && !data_ready);
        ovr_d   = complete && valid_q && !data_ready;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            sync_q  <= '0;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            dout_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sync_q  <= {sync_q[0], rx_in};
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            dout_q  <= dout_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
        end
    end

    assign data_out   = dout_q;
    assign data_valid = valid_q;
    assign frame_err  = ferr_q;
    assign overrun    = ovr_q;
    assign busy       = state_q != IDLE;
endmodule

// File: tb/tb_rx_frame_ctrl.sv
// tb_rx_frame_ctrl: directed frames against rx_frame_ctrl with hand-derived timing and pulse counts.
module tb_rx_frame_ctrl;
    localparam int BP = 54;

    logic       clock = 1'b0, reset = 1'b1, enable = 1'b1, rx_in = 1'b0, data_ready = 1'b1;
    logic [7:0] data_out;
    logic       data_valid, frame_err, overrun, busy;

    int vectors = 0, miscompares = 0;
    int cyc = 0, rise_cyc = -1, tot_valid = 0, tot_ferr = 0, tot_ovr = 0, tot_busy = 0, tot_both = 0;
    logic pv = 1'b0;
    int s_valid, s_ferr, s_ovr, s_busy, t0;

    rx_frame_ctrl #(.BIT_PERIOD(BP), .DATA_BITS(8)) dut (
        .clock(clock), .reset(reset), .enable(enable), .rx_in(rx_in), .data_ready(data_ready),
        .data_out(data_out), .data_valid(data_valid), .frame_err(frame_err), .overrun(overrun), .busy(busy)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        if (data_valid && !pv) rise_cyc = cyc;
        pv = data_valid;
        tot_valid += int'(data_valid);
        tot_ferr  += int'(frame_err);
        tot_ovr   += int'(overrun);
        tot_busy  += int'(busy);
        if (frame_err && overrun) tot_both++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic snap();
        s_valid = tot_valid; s_ferr = tot_ferr; s_ovr = tot_ovr; s_busy = tot_busy;
    endtask

    task automatic send(input logic [7:0] d, input logic stop_val, input int stop_len);
        rx_in = 1'b1;
        repeat (BP) @(negedge clock);
        for (int i = 0; i < 8; i++) begin
            rx_in = d[i];
            repeat (BP) @(negedge clock);
        end
        rx_in = stop_val;
        repeat (stop_len) @(negedge clock);
        rx_in = 1'b0;
        repeat (60) @(negedge clock);
    endtask

    task automatic send_part(input logic [7:0] d, input int nbits);
        rx_in = 1'b1;
        repeat (BP) @(negedge clock);
        for (int i = 0; i < nbits; i++) begin
            rx_in = d[i];
            repeat (BP) @(negedge clock);
        end
        rx_in = d[nbits];
        repeat (BP / 2) @(negedge clock);
    endtask

    initial begin
        repeat (3) @(negedge clock);
        reset = 1'b0;
        check("rst_data_out", 32'(data_out), 0);
        check("rst_valid", 32'(data_valid), 0);
        check("rst_ferr", 32'(frame_err), 0);
        check("rst_ovr", 32'(overrun), 0);
        check("rst_busy", 32'(busy), 0);
        repeat (5) @(negedge clock);

        // 0xA5: valid rises in cycle 514, i.e. 516 posedges after rx_in is driven high
        snap(); t0 = cyc;
        send(8'hA5, 1'b0, BP);
        check("a5_data", 32'(data_out), 32'hA5);
        check("a5_rise_time", 32'(rise_cyc - t0), 516);
        check("a5_valid_cycles", 32'(tot_valid - s_valid), 1);
        check("a5_no_ferr", 32'(tot_ferr - s_ferr), 0);
        check("a5_idle", 32'(busy), 0);

        // 10-cycle glitch: busy in cycles 1..27
        snap();
        rx_in = 1'b1;
        repeat (10) @(negedge clock);
        rx_in = 1'b0;
        repeat (60) @(negedge clock);
        check("glitch_busy_cycles", 32'(tot_busy - s_busy), 27);
        check("glitch_no_valid", 32'(tot_valid - s_valid), 0);
        check("glitch_no_ferr", 32'(tot_ferr - s_ferr), 0);
        check("glitch_idle", 32'(busy), 0);

        // Bad stop bit then good frame
        snap();
        send(8'h5A, 1'b1, 200);
        check("ferr_pulses", 32'(tot_ferr - s_ferr), 1);
        check("ferr_no_valid", 32'(tot_valid - s_valid), 0);
        check("ferr_data_kept", 32'(data_out), 32'hA5);
        snap();
        send(8'h0F, 1'b0, BP);
        check("f0f_data", 32'(data_out), 32'h0F);
        check("f0f_valid_cycles", 32'(tot_valid - s_valid), 1);
        check("f0f_no_ferr", 32'(tot_ferr - s_ferr), 0);

        // Backpressure and overrun
        data_ready = 1'b0;
        snap();
        send(8'h3C, 1'b0, BP);
        check("bp_3c_data", 32'(data_out), 32'h3C);
        check("bp_3c_valid", 32'(data_valid), 1);
        check("bp_3c_no_ovr", 32'(tot_ovr - s_ovr), 0);
        send(8'h81, 1'b0, BP);
        check("ovr_pulses", 32'(tot_ovr - s_ovr), 1);
        check("ovr_data_kept", 32'(data_out), 32'h3C);
        check("ovr_valid_held", 32'(data_valid), 1);
        data_ready = 1'b1;
        @(negedge clock);
        check("drain_valid_clear", 32'(data_valid), 0);
        check("drain_data_kept", 32'(data_out), 32'h3C);

        // Reset mid-payload
        snap();
        send_part(8'hFF, 4);
        check("mid_busy", 32'(busy), 1);
        reset = 1'b1; rx_in = 1'b0;
        @(negedge clock);
        check("mrst_data_out", 32'(data_out), 0);
        check("mrst_valid", 32'(data_valid), 0);
        check("mrst_busy", 32'(busy), 0);
        check("mrst_no_pulses", 32'(tot_ferr - s_ferr + tot_ovr - s_ovr), 0);
        reset = 1'b0;
        repeat (10) @(negedge clock);
        send(8'h55, 1'b0, BP);
        check("f55_data", 32'(data_out), 32'h55);

        // Enable dropped mid-payload
        snap();
        send_part(8'hFF, 2);
        check("en_busy_before", 32'(busy), 1);
        enable = 1'b0; rx_in = 1'b0;
        @(negedge clock);
        check("en_busy_after", 32'(busy), 0);
        repeat (20) @(negedge clock);
        check("en_no_valid", 32'(tot_valid - s_valid), 0);
        check("en_no_ferr", 32'(tot_ferr - s_ferr), 0);
        check("en_data_kept", 32'(data_out), 32'h55);
        enable = 1'b1;
        repeat (5) @(negedge clock);
        send(8'hC3, 1'b0, BP);
        check("fc3_data", 32'(data_out), 32'hC3);
        check("never_both_pulses", 32'(tot_both), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/rx_frame_ctrl.md
RX_FRAME_CTRL -- requirements
Module: rx_frame_ctrl

Interface
REQ-001 Parameter BIT_PERIOD, default 54, clock cycles per optical bit; legal range >= 4.
REQ-002 Parameter DATA_BITS, default 8, payload bits per frame; legal range 1..16.
REQ-003 clock  input  1  system clock; all logic on posedge clock.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 enable  input  1  receiver run enable; low aborts and holds FSM in IDLE.
REQ-006 rx_in  input  1  raw photodiode comparator output, asynchronous to clock.
REQ-007 data_ready  input  1  downstream consumer accepts data_out when high with data_valid.
REQ-008 data_out  output  DATA_BITS  last received payload, bit 0 = first bit on line.
REQ-009 data_valid  output  1  data_out holds an unconsumed payload.
REQ-010 frame_err  output  1  one-cycle pulse, stop bit invalid.
REQ-011 overrun  output  1  one-cycle pulse, completed frame dropped because output still held.
REQ-012 busy  output  1  high whenever FSM is not IDLE.

Function
REQ-013 rx_in SHALL pass through a 2-flop synchronizer; rx_s denotes its output; all decisions use rx_s only.
REQ-014 Line format SHALL be: idle 0, start bit 1, DATA_BITS payload bits LSB first, stop bit 0.
REQ-015 FSM states SHALL be IDLE, START, DATA, STOP, RECOVER.
REQ-016 Cycle 0 is the first cycle IDLE observes rx_s=1 with enable=1; FSM SHALL enter START at cycle 1.
REQ-017 With H = floor(BIT_PERIOD/2): start sampled at cycle H; payload bit k sampled at cycle H+(k+1)*BIT_PERIOD; stop sampled at cycle H+(DATA_BITS+1)*BIT_PERIOD.
REQ-018 Start sample = 0 SHALL return FSM to IDLE silently (glitch reject, no frame_err).
REQ-019 Start sample = 1 SHALL enter DATA; after DATA_BITS samples FSM SHALL enter STOP.
REQ-020 Stop sample = 0 SHALL complete the frame and return to IDLE next cycle.
REQ-021 Stop sample = 1 SHALL pulse frame_err for one cycle, discard payload, enter RECOVER; RECOVER exits to IDLE on first cycle rx_s=0.
REQ-022 On completion, if data_valid=0 or (data_valid & data_ready) that cycle: data_out loaded, data_valid=1 from next cycle.
REQ-023 On completion with data_valid=1 and data_ready=0: overrun pulses one cycle; data_out unchanged; new payload dropped.
REQ-024 data_valid SHALL clear the cycle after data_valid & data_ready, unless reloaded per REQ-022 in the same cycle.
REQ-025 Bit-period counter SHALL wrap exactly at BIT_PERIOD-1; no cumulative drift across a frame.
REQ-026 enable=0 in any state SHALL force IDLE next cycle, discard partial payload; data_valid/data_out unaffected; no frame_err.
REQ-027 frame_err and overrun SHALL never assert in the same cycle.
REQ-028 busy SHALL be combinationally (state != IDLE).

Reset
REQ-029 reset SHALL set state IDLE, counters 0, synchronizer flops 0, shift register 0.
REQ-030 reset SHALL drive data_out=0, data_valid=0, frame_err=0, overrun=0, busy=0 from the following cycle.
REQ-031 reset mid-frame SHALL discard the frame with no pulse outputs.

Verification
REQ-032 Frame 0xA5, BIT_PERIOD=54, data_ready=1 -> data_out=0xA5, data_valid high at cycle 514 for exactly 1 cycle.
REQ-033 rx_in high 10 cycles then low -> busy high ~27 cycles, returns IDLE, no data_valid, no frame_err.
REQ-034 Frame 0x5A with stop bit held 1 for 200 cycles -> frame_err single pulse, no data_valid; following frame 0x0F received correctly.
REQ-035 data_ready=0, frames 0x3C then 0x81 -> data_out=0x3C, overrun single pulse at second stop; data_ready=1 -> data_valid clears next cycle.
REQ-036 reset asserted during payload bit 4 -> all outputs 0 next cycle; subsequent frame 0x55 received correctly.
REQ-037 enable dropped during payload bit 2 -> busy 0 next cycle, no data_valid, no frame_err; re-enable, frame 0xC3 received correctly.
